// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver and the decoder that feeds it:
// branch condition encodings, resolver FSM states and instruction-class flags.
// Pure declarations; no logic, no latency, no flow control.
package branch_resolver_pkg;

    // funct3 branch condition encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV2 = 3'b010;  // reserved: never taken, flagged illegal
    localparam logic [2:0] F3_RSV3 = 3'b011;  // reserved: never taken, flagged illegal
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SQUASH   = 2'd2,
        ST_FAULT    = 2'd3
    } br_state_t;

    // One-hot instruction class as produced by the decoder; all zero = non-control
    typedef struct packed {
        logic isBranch;
        logic isJal;
        logic isJalr;
    } ctrl_class_t;

    function automatic logic is_ctrl(ctrl_class_t c);
        return c.isBranch | c.isJal | c.isJalr;
    endfunction

    function automatic logic is_link(ctrl_class_t c);
        return c.isJal | c.isJalr;
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Decode-to-execute instruction bus plus the resolver's redirect/status returns.
// master: decoder side (drives the instruction, observes the results).
// slave: resolver side. No handshake: one instruction per cycle, squash drops it.
interface branch_resolver_if #(
    parameter int XLEN   = 32,
    parameter int CNTLEN = 16
);
    // instruction presented to the resolver
    logic              valid;
    logic [XLEN-1:0]   pcIn;
    logic [XLEN-1:0]   rs1Val;
    logic [XLEN-1:0]   rs2Val;
    logic [XLEN-1:0]   imm;
    logic [2:0]        funct3;
    logic              isBranch;
    logic              isJal;
    logic              isJalr;

    // redirect, writeback and status returned by the resolver
    logic [XLEN-1:0]   pcBranch;
    logic              originPc;
    logic              squash;
    logic              linkWe;
    logic [XLEN-1:0]   linkVal;
    logic              misaligned;
    logic              illegalCond;
    logic [CNTLEN-1:0] branchCount;
    logic [CNTLEN-1:0] takenCount;

    modport master (
        output valid, pcIn, rs1Val, rs2Val, imm, funct3, isBranch, isJal, isJalr,
        input  pcBranch, originPc, squash, linkWe, linkVal, misaligned, illegalCond,
               branchCount, takenCount
    );

    modport slave (
        input  valid, pcIn, rs1Val, rs2Val, imm, funct3, isBranch, isJal, isJalr,
        output pcBranch, originPc, squash, linkWe, linkVal, misaligned, illegalCond,
               branchCount, takenCount
    );

endinterface

// File: rtl/branch_compare.sv
// Branch condition evaluator: rs1Val/rs2Val compared per funct3 -> taken, illegal.
// Purely combinational, zero latency.
// No flow control; the caller decides whether the result is used.
module branch_compare
    import branch_resolver_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1Val,
    input  logic [XLEN-1:0] rs2Val,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:           taken = (rs1Val == rs2Val);
            F3_BNE:           taken = (rs1Val != rs2Val);
            F3_BLT:           taken = ($signed(rs1Val) <  $signed(rs2Val));
            F3_BGE:           taken = ($signed(rs1Val) >= $signed(rs2Val));
            F3_BLTU:          taken = (rs1Val <  rs2Val);
            F3_BGEU:          taken = (rs1Val >= rs2Val);
            F3_RSV2, F3_RSV3: illegal = 1'b1;
            default:          taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage control-transfer resolver: evaluates branches/JAL/JALR, redirects
// fetch (pcBranch/originPc) and squashes wrong-path work; all outputs registered, 1 cycle.
// No stall input: after a taken transfer the next two presented instructions are squashed.
//
// Ports: clk, reset (sync, active-high), bus (branch_resolver_if.slave) carrying the
// decoded instruction in and pcBranch/originPc/squash/link/fault/counter outputs back.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CNTLEN = 16
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolver_if.slave bus
);

    // JALR clears bit 0 of the computed target
    localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);

    br_state_t       state;
    ctrl_class_t     cls;
    logic            cond_taken;
    logic            cond_illegal;
    logic            accept;
    logic            xfer_taken;
    logic            target_aligned;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link_addr;

    branch_compare #(.XLEN(XLEN)) u_cmp (
        .rs1Val  (bus.rs1Val),
        .rs2Val  (bus.rs2Val),
        .funct3  (bus.funct3),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    assign cls = {bus.isBranch, bus.isJal, bus.isJalr};

    // squash mirrors "state != IDLE"; both terms kept so intent is explicit
    assign accept = bus.valid && !bus.squash && (state == ST_IDLE);

    assign xfer_taken = is_link(cls) || (cls.isBranch && cond_taken);

    assign target = cls.isJalr ? ((bus.rs1Val + bus.imm) & JALR_MASK)
                               : (bus.pcIn + bus.imm);

    assign target_aligned = (target[1:0] == 2'b00);
    assign link_addr      = bus.pcIn + XLEN'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            bus.pcBranch    <= '0;
            bus.originPc    <= 1'b0;
            bus.squash      <= 1'b0;
            bus.linkWe      <= 1'b0;
            bus.linkVal     <= '0;
            bus.misaligned  <= 1'b0;
            bus.illegalCond <= 1'b0;
            bus.branchCount <= '0;
            bus.takenCount  <= '0;
        end else begin
            // single-cycle pulses default low
            bus.originPc    <= 1'b0;
            bus.linkWe      <= 1'b0;
            bus.illegalCond <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_ctrl(cls)) begin
                            bus.branchCount <= bus.branchCount + CNTLEN'(1);
                        end
                        if (xfer_taken) begin
                            bus.takenCount <= bus.takenCount + CNTLEN'(1);
                        end
                        // link is written even when the target faults
                        if (is_link(cls)) begin
                            bus.linkWe  <= 1'b1;
                            bus.linkVal <= link_addr;
                        end
                        if (cls.isBranch && cond_illegal) begin
                            bus.illegalCond <= 1'b1;
                        end
                        if (xfer_taken) begin
                            bus.squash <= 1'b1;
                            if (target_aligned) begin
                                state        <= ST_REDIRECT;
                                bus.pcBranch <= target;
                                bus.originPc <= 1'b1;
                            end else begin
                                // no redirect on a bad target; only reset recovers
                                state          <= ST_FAULT;
                                bus.misaligned <= 1'b1;
                            end
                        end
                    end
                end
                ST_REDIRECT: begin
                    // squash stays high for a second cycle
                    state <= ST_SQUASH;
                end
                ST_SQUASH: begin
                    state      <= ST_IDLE;
                    bus.squash <= 1'b0;
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
    import branch_resolver_pkg::*;

    localparam int XW = 32;
    localparam int CW = 8;  // narrow counters so wrap-around is reachable quickly

    logic clk = 1'b0;
    logic reset = 1'b1;

    branch_resolver_if #(.XLEN(XW), .CNTLEN(CW)) bus ();

    branch_resolver #(.XLEN(XW), .CNTLEN(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [CW-1:0] exp_b = '0;
    logic [CW-1:0] exp_t = '0;

    typedef struct {
        logic        vld;
        logic [2:0]  cls;   // {isBranch, isJal, isJalr}
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        tk;    // expected redirect
        logic [31:0] pcb;   // expected pcBranch afterwards
        logic        lwe;
        logic [31:0] lval;
        logic        ill;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] cls, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm);
        bus.valid    = v;
        bus.isBranch = cls[2];
        bus.isJal    = cls[1];
        bus.isJalr   = cls[0];
        bus.funct3   = f3;
        bus.pcIn     = pc;
        bus.rs1Val   = rs1;
        bus.rs2Val   = rs2;
        bus.imm      = imm;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pcBranch"},    bus.pcBranch, 32'h0);
        chk({tag, ".originPc"},    32'(bus.originPc), 32'h0);
        chk({tag, ".squash"},      32'(bus.squash), 32'h0);
        chk({tag, ".linkWe"},      32'(bus.linkWe), 32'h0);
        chk({tag, ".linkVal"},     bus.linkVal, 32'h0);
        chk({tag, ".misaligned"},  32'(bus.misaligned), 32'h0);
        chk({tag, ".illegalCond"}, 32'(bus.illegalCond), 32'h0);
        chk({tag, ".branchCount"}, 32'(bus.branchCount), 32'h0);
        chk({tag, ".takenCount"},  32'(bus.takenCount), 32'h0);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, ".branchCount"}, 32'(bus.branchCount), 32'(exp_b));
        chk({tag, ".takenCount"},  32'(bus.takenCount), 32'(exp_t));
    endtask

    initial begin
        //           vld  cls     f3      pc           rs1          rs2          imm          tk   pcb          lwe  lval         ill
        tbl[0]  = '{1'b1, 3'b100, 3'b000, 32'h100, 32'h5,        32'h5,        32'h20,       1'b1, 32'h120,  1'b0, 32'h0,  1'b0};
        tbl[1]  = '{1'b1, 3'b100, 3'b000, 32'h100, 32'h5,        32'h6,        32'h20,       1'b0, 32'h120,  1'b0, 32'h0,  1'b0};
        tbl[2]  = '{1'b1, 3'b100, 3'b001, 32'h200, 32'h5,        32'h6,        32'h10,       1'b1, 32'h210,  1'b0, 32'h0,  1'b0};
        tbl[3]  = '{1'b1, 3'b100, 3'b100, 32'h300, 32'hFFFFFFFF, 32'h1,        32'h8,        1'b1, 32'h308,  1'b0, 32'h0,  1'b0};
        tbl[4]  = '{1'b1, 3'b100, 3'b110, 32'h300, 32'hFFFFFFFF, 32'h1,        32'h8,        1'b0, 32'h308,  1'b0, 32'h0,  1'b0};
        tbl[5]  = '{1'b1, 3'b100, 3'b101, 32'h400, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFC, 1'b1, 32'h3FC,  1'b0, 32'h0,  1'b0};
        tbl[6]  = '{1'b1, 3'b100, 3'b111, 32'h400, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFC, 1'b0, 32'h3FC,  1'b0, 32'h0,  1'b0};
        tbl[7]  = '{1'b1, 3'b100, 3'b010, 32'h500, 32'h7,        32'h7,        32'h4,        1'b0, 32'h3FC,  1'b0, 32'h0,  1'b1};
        tbl[8]  = '{1'b1, 3'b100, 3'b011, 32'h500, 32'h7,        32'h8,        32'h4,        1'b0, 32'h3FC,  1'b0, 32'h0,  1'b1};
        tbl[9]  = '{1'b1, 3'b000, 3'b000, 32'h600, 32'h1,        32'h1,        32'h40,       1'b0, 32'h3FC,  1'b0, 32'h0,  1'b0};
        tbl[10] = '{1'b1, 3'b010, 3'b000, 32'h80,  32'h0,        32'h0,        32'hFFFFFF80, 1'b1, 32'h0,    1'b1, 32'h84, 1'b0};
        tbl[11] = '{1'b1, 3'b001, 3'b000, 32'h40,  32'h105,      32'h0,        32'h3,        1'b1, 32'h108,  1'b1, 32'h44, 1'b0};
        tbl[12] = '{1'b1, 3'b001, 3'b000, 32'h44,  32'h1001,     32'h0,        32'h0,        1'b1, 32'h1000, 1'b1, 32'h48, 1'b0};
        tbl[13] = '{1'b1, 3'b100, 3'b110, 32'h500, 32'h1,        32'hFFFFFFFF, 32'h4,        1'b1, 32'h504,  1'b0, 32'h0,  1'b0};
        tbl[14] = '{1'b0, 3'b100, 3'b000, 32'h700, 32'h3,        32'h3,        32'h8,        1'b0, 32'h504,  1'b0, 32'h0,  1'b0};

        // ---- reset state ----
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;

        // ---- table: each vector followed by two idle cycles ----
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].vld, tbl[i].cls, tbl[i].f3, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
            if (tbl[i].vld && (tbl[i].cls != 3'b000)) exp_b = exp_b + 1'b1;
            if (tbl[i].tk) exp_t = exp_t + 1'b1;
            tick();
            chk($sformatf("vec%0d.originPc", i), 32'(bus.originPc), 32'(tbl[i].tk));
            chk($sformatf("vec%0d.squash", i), 32'(bus.squash), 32'(tbl[i].tk));
            chk($sformatf("vec%0d.pcBranch", i), bus.pcBranch, tbl[i].pcb);
            chk($sformatf("vec%0d.linkWe", i), 32'(bus.linkWe), 32'(tbl[i].lwe));
            if (tbl[i].lwe) chk($sformatf("vec%0d.linkVal", i), bus.linkVal, tbl[i].lval);
            chk($sformatf("vec%0d.illegalCond", i), 32'(bus.illegalCond), 32'(tbl[i].ill));
            chk($sformatf("vec%0d.misaligned", i), 32'(bus.misaligned), 32'h0);
            chk_counts($sformatf("vec%0d", i));
            idle();
            tick();
            chk($sformatf("vec%0d.n2.originPc", i), 32'(bus.originPc), 32'h0);
            chk($sformatf("vec%0d.n2.squash", i), 32'(bus.squash), 32'(tbl[i].tk));
            chk($sformatf("vec%0d.n2.illegalCond", i), 32'(bus.illegalCond), 32'h0);
            tick();
            chk($sformatf("vec%0d.n3.squash", i), 32'(bus.squash), 32'h0);
        end

        // ---- zero-bubble after a not-taken branch ----
        drive(1'b1, 3'b100, F3_BLTU, 32'h800, 32'hFFFFFFFF, 32'h1, 32'h8);
        exp_b = exp_b + 1'b1;
        tick();
        chk("bubble.nt.squash", 32'(bus.squash), 32'h0);
        chk("bubble.nt.originPc", 32'(bus.originPc), 32'h0);
        drive(1'b1, 3'b100, F3_BEQ, 32'h800, 32'h9, 32'h9, 32'h40);
        exp_b = exp_b + 1'b1;
        exp_t = exp_t + 1'b1;
        tick();
        chk("bubble.tk.originPc", 32'(bus.originPc), 32'h1);
        chk("bubble.tk.pcBranch", bus.pcBranch, 32'h840);
        chk_counts("bubble");
        idle();
        tick();
        tick();

        // ---- JAL followed by a wrong-path BNE that must be squashed ----
        drive(1'b1, 3'b010, 3'b000, 32'h80, 32'h0, 32'h0, 32'hFFFFFF80);
        exp_b = exp_b + 1'b1;
        exp_t = exp_t + 1'b1;
        tick();
        chk("jal.originPc", 32'(bus.originPc), 32'h1);
        chk("jal.pcBranch", bus.pcBranch, 32'h0);
        chk("jal.linkVal", bus.linkVal, 32'h84);
        drive(1'b1, 3'b100, F3_BNE, 32'h900, 32'h1, 32'h2, 32'h100);
        tick();
        chk("wrongpath.originPc", 32'(bus.originPc), 32'h0);
        chk("wrongpath.squash", 32'(bus.squash), 32'h1);
        chk("wrongpath.linkWe", 32'(bus.linkWe), 32'h0);
        chk_counts("wrongpath");
        idle();
        tick();
        chk("wrongpath.after.squash", 32'(bus.squash), 32'h0);
        chk("wrongpath.after.pcBranch", bus.pcBranch, 32'h0);
        chk_counts("wrongpath.after");

        // ---- reset during REDIRECT, with a taken branch still presented ----
        drive(1'b1, 3'b100, F3_BEQ, 32'hA00, 32'h3, 32'h3, 32'h10);
        tick();
        chk("rstmid.originPc", 32'(bus.originPc), 32'h1);
        reset = 1'b1;
        tick();
        chk_all_zero("rstmid");
        reset = 1'b0;
        idle();
        tick();
        chk("rstmid.after.originPc", 32'(bus.originPc), 32'h0);
        chk("rstmid.after.squash", 32'(bus.squash), 32'h0);
        exp_b = '0;
        exp_t = '0;

        // ---- counter wrap: all-ones then one more taken transfer ----
        for (int k = 0; k < (1 << CW); k++) begin
            drive(1'b1, 3'b100, F3_BEQ, 32'h0, 32'h1, 32'h1, 32'h10);
            tick();
            idle();
            tick();
            tick();
            if (k == (1 << CW) - 2) begin
                chk("wrap.full.branchCount", 32'(bus.branchCount), 32'hFF);
                chk("wrap.full.takenCount", 32'(bus.takenCount), 32'hFF);
            end
        end
        chk("wrap.zero.branchCount", 32'(bus.branchCount), 32'h0);
        chk("wrap.zero.takenCount", 32'(bus.takenCount), 32'h0);

        // ---- misaligned JALR -> sticky FAULT ----
        drive(1'b1, 3'b001, 3'b000, 32'h40, 32'h203, 32'h0, 32'h0);
        tick();
        chk("fault.misaligned", 32'(bus.misaligned), 32'h1);
        chk("fault.squash", 32'(bus.squash), 32'h1);
        chk("fault.originPc", 32'(bus.originPc), 32'h0);
        chk("fault.linkWe", 32'(bus.linkWe), 32'h1);
        chk("fault.linkVal", bus.linkVal, 32'h44);
        chk("fault.branchCount", 32'(bus.branchCount), 32'h1);
        chk("fault.takenCount", 32'(bus.takenCount), 32'h1);
        drive(1'b1, 3'b100, F3_BEQ, 32'h100, 32'h5, 32'h5, 32'h20);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fault.hold%0d.misaligned", k), 32'(bus.misaligned), 32'h1);
            chk($sformatf("fault.hold%0d.squash", k), 32'(bus.squash), 32'h1);
            chk($sformatf("fault.hold%0d.originPc", k), 32'(bus.originPc), 32'h0);
            chk($sformatf("fault.hold%0d.linkWe", k), 32'(bus.linkWe), 32'h0);
            chk($sformatf("fault.hold%0d.branchCount", k), 32'(bus.branchCount), 32'h1);
        end
        idle();
        reset = 1'b1;
        tick();
        chk_all_zero("fault.reset");
        reset = 1'b0;
        tick();
        chk("fault.reset.after.squash", 32'(bus.squash), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
